// File: rtl/ahb_matrix_pkg.sv
// Shared AHB encodings and the address/control bundle used across the DMA bus matrix.
package ahb_matrix_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001
  } hburst_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        mastlock;
  } addr_ctrl_t;

endpackage

// File: rtl/ahb_input_stage_dma.sv
// Slave-port input stage: passes address/control straight through when granted,
// otherwise holds the transfer and stalls the master until the output stage issues it.
module ahb_input_stage_dma
  import ahb_matrix_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic [3:0]  HMASTERS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  input  logic        active_ip,
  input  logic        readyout_ip,
  input  logic        resp_ip,
  output logic        sel_ip,
  output logic [31:0] addr_ip,
  output logic [1:0]  trans_ip,
  output logic        write_ip,
  output logic [2:0]  size_ip,
  output logic [2:0]  burst_ip,
  output logic [3:0]  prot_ip,
  output logic [3:0]  master_ip,
  output logic        mastlock_ip,
  output logic        held_tran_ip,
  output logic        HREADYOUTS,
  output logic        HRESPS
);

  addr_ctrl_t live;
  addr_ctrl_t pres;
  addr_ctrl_t hold_q, hold_d;
  logic       reg_hold_q, reg_hold_d;
  logic       override_q, override_d;
  logic       data_ph_q, data_ph_d;
  logic       new_tran;
  logic       issue;
  logic       ovr_clear;

  always_comb begin
    live.addr     = HADDRS;
    live.trans    = HTRANSS;
    live.write    = HWRITES;
    live.size     = HSIZES;
    live.burst    = HBURSTS;
    live.prot     = HPROTS;
    live.master   = HMASTERS;
    live.mastlock = HMASTLOCKS;
  end

  always_comb begin
    new_tran     = HSELS & HTRANSS[1] & HREADYS;
    held_tran_ip = reg_hold_q | new_tran;
    issue        = held_tran_ip & active_ip & readyout_ip;
    ovr_clear    = HREADYS & ((HTRANSS == HTRANS_NONSEQ) | (HTRANSS == HTRANS_IDLE));
  end

  // A held transfer may have been interleaved with another master, so a held
  // SEQ is re-issued as a fresh INCR NONSEQ and later live SEQ beats stay INCR.
  always_comb begin
    pres   = live;
    sel_ip = HSELS;
    if (reg_hold_q) begin
      pres   = hold_q;
      sel_ip = 1'b1;
      if (hold_q.trans == HTRANS_SEQ) begin
        pres.trans = HTRANS_NONSEQ;
        pres.burst = HBURST_INCR;
      end
    end else if (override_q && (HTRANSS == HTRANS_SEQ)) begin
      pres.burst = HBURST_INCR;
    end
  end

  always_comb begin
    addr_ip     = pres.addr;
    trans_ip    = pres.trans;
    write_ip    = pres.write;
    size_ip     = pres.size;
    burst_ip    = pres.burst;
    prot_ip     = pres.prot;
    master_ip   = pres.master;
    mastlock_ip = pres.mastlock;
  end

  always_comb begin
    hold_d     = hold_q;
    reg_hold_d = reg_hold_q;
    override_d = override_q;
    data_ph_d  = data_ph_q;

    if (new_tran && !issue) begin
      hold_d     = live;
      reg_hold_d = 1'b1;
      override_d = 1'b1;
    end else begin
      if (issue) reg_hold_d = 1'b0;
      if (ovr_clear) override_d = 1'b0;
    end

    if (issue) data_ph_d = 1'b1;
    else if (readyout_ip) data_ph_d = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_q     <= '0;
      reg_hold_q <= 1'b0;
      override_q <= 1'b0;
      data_ph_q  <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      reg_hold_q <= reg_hold_d;
      override_q <= override_d;
      data_ph_q  <= data_ph_d;
    end
  end

  always_comb begin
    HREADYOUTS = reg_hold_q ? 1'b0 : (data_ph_q ? readyout_ip : 1'b1);
    HRESPS     = data_ph_q ? resp_ip : HRESP_OKAY;
  end

endmodule

// File: tb/tb_ahb_input_stage_dma.sv
// Self-checking bench for ahb_input_stage_dma: directed scenarios plus random traffic
// compared against a transfer-level model of the pending/held request.
module tb_ahb_input_stage_dma;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic [3:0]  HMASTERS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        active_ip;
  logic        readyout_ip;
  logic        resp_ip;
  logic        sel_ip;
  logic [31:0] addr_ip;
  logic [1:0]  trans_ip;
  logic        write_ip;
  logic [2:0]  size_ip;
  logic [2:0]  burst_ip;
  logic [3:0]  prot_ip;
  logic [3:0]  master_ip;
  logic        mastlock_ip;
  logic        held_tran_ip;
  logic        HREADYOUTS;
  logic        HRESPS;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_input_stage_dma dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .active_ip(active_ip), .readyout_ip(readyout_ip),
    .resp_ip(resp_ip), .sel_ip(sel_ip), .addr_ip(addr_ip), .trans_ip(trans_ip),
    .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip),
    .prot_ip(prot_ip), .master_ip(master_ip), .mastlock_ip(mastlock_ip),
    .held_tran_ip(held_tran_ip), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  // Model: the one pending transfer the stage is sitting on, if any.
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        lock;
  } xfer_t;

  bit    m_pending;
  xfer_t m_xfer;
  bit    m_incr_mode;
  bit    m_in_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit sampled_xfer();
    return HSELS && (HTRANSS == 2'd2 || HTRANSS == 2'd3) && HREADYS;
  endfunction

  task automatic model_reset();
    m_pending   = 0;
    m_xfer      = '{default: '0};
    m_incr_mode = 0;
    m_in_data   = 0;
  endtask

  task automatic model_check();
    xfer_t e;
    logic  e_sel;
    if (m_pending) begin
      e       = m_xfer;
      e_sel   = 1'b1;
      e.trans = 2'd2;
      if (m_xfer.trans == 2'd3) e.burst = 3'd1;
    end else begin
      e = '{addr: HADDRS, trans: HTRANSS, write: HWRITES, size: HSIZES,
            burst: HBURSTS, prot: HPROTS, master: HMASTERS, lock: HMASTLOCKS};
      e_sel = HSELS;
      if (m_incr_mode && HTRANSS == 2'd3) e.burst = 3'd1;
    end
    chk("sel",      sel_ip,       e_sel);
    chk("addr",     addr_ip,      e.addr);
    chk("trans",    trans_ip,     e.trans);
    chk("write",    write_ip,     e.write);
    chk("size",     size_ip,      e.size);
    chk("burst",    burst_ip,     e.burst);
    chk("prot",     prot_ip,      e.prot);
    chk("master",   master_ip,    e.master);
    chk("lock",     mastlock_ip,  e.lock);
    chk("held",     held_tran_ip, m_pending || sampled_xfer());
    chk("hreadyout", HREADYOUTS,  m_pending ? 1'b0 : (m_in_data ? readyout_ip : 1'b1));
    chk("hresp",    HRESPS,       m_in_data ? resp_ip : 1'b0);
  endtask

  task automatic model_update();
    bit nt, granted;
    nt      = sampled_xfer();
    granted = (m_pending || nt) && active_ip && readyout_ip;
    if (nt && !granted) begin
      m_pending   = 1;
      m_xfer      = '{addr: HADDRS, trans: HTRANSS, write: HWRITES, size: HSIZES,
                      burst: HBURSTS, prot: HPROTS, master: HMASTERS, lock: HMASTLOCKS};
      m_incr_mode = 1;
    end else begin
      if (granted) m_pending = 0;
      if (HREADYS && (HTRANSS == 2'd0 || HTRANSS == 2'd2)) m_incr_mode = 0;
    end
    if (granted) m_in_data = 1;
    else if (readyout_ip) m_in_data = 0;
  endtask

  // Inputs change at the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    #1;
    model_check();
  endtask

  task automatic adv();
    model_update();
    @(negedge HCLK);
  endtask

  task automatic set_idle();
    HSELS = 0; HADDRS = '0; HTRANSS = 2'd0; HWRITES = 0; HSIZES = 3'd2;
    HBURSTS = 3'd0; HPROTS = 4'h3; HMASTERS = 4'h1; HMASTLOCKS = 0;
    HREADYS = 1; active_ip = 0; readyout_ip = 1; resp_ip = 0;
  endtask

  task automatic set_xfer(input logic [31:0] a, input logic [1:0] t, input logic [2:0] b,
                          input logic act, input logic rdy);
    HSELS = 1; HADDRS = a; HTRANSS = t; HBURSTS = b; HWRITES = 1;
    HREADYS = 1; active_ip = act; readyout_ip = rdy; resp_ip = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 0;
    set_idle();
    model_reset();
    @(negedge HCLK);
    step();
    chk("rst_hreadyout", HREADYOUTS, 1'b1);
    chk("rst_hresp", HRESPS, 1'b0);
    HRESETn = 1;
    adv();

    // Pass-through
    set_xfer(32'h2000_0010, 2'd2, 3'd0, 1, 1);
    step();
    chk("pt_held", held_tran_ip, 1'b1);
    chk("pt_addr", addr_ip, 32'h2000_0010);
    chk("pt_ready", HREADYOUTS, 1'b1);
    adv();
    set_idle(); readyout_ip = 0;
    step();
    chk("pt_dataph", HREADYOUTS, 1'b0);
    adv();
    readyout_ip = 1;
    step(); adv();

    // Hold: not granted for the sample cycle plus two stall cycles, then granted
    set_xfer(32'h4000_0000, 2'd2, 3'd0, 0, 1);
    step();
    chk("hold_sample_ready", HREADYOUTS, 1'b1);
    adv();
    for (int i = 0; i < 3; i++) begin
      HREADYS = 0; HSELS = 0; HTRANSS = 2'd0; HADDRS = $urandom;
      active_ip = (i == 2);
      step();
      chk("hold_addr", addr_ip, 32'h4000_0000);
      chk("hold_ready", HREADYOUTS, 1'b0);
      adv();
    end
    set_idle(); readyout_ip = 0;
    step();
    chk("hold_dph_wait", HREADYOUTS, 1'b0);
    adv();
    readyout_ip = 1;
    step();
    chk("hold_dph_done", HREADYOUTS, 1'b1);
    adv();

    // Override: INCR4 with the second beat held
    set_xfer(32'h0000_1000, 2'd2, 3'd3, 1, 1);
    step(); adv();
    set_xfer(32'h0000_1004, 2'd3, 3'd3, 0, 1);
    step();
    chk("ovr_live_burst", burst_ip, 3'd3);
    adv();
    HREADYS = 0; HSELS = 0; active_ip = 1;
    step();
    chk("ovr_held_trans", trans_ip, 2'd2);
    chk("ovr_held_burst", burst_ip, 3'd1);
    chk("ovr_held_addr", addr_ip, 32'h0000_1004);
    adv();
    set_xfer(32'h0000_1008, 2'd3, 3'd3, 1, 1);
    step();
    chk("ovr_seq_burst", burst_ip, 3'd1);
    adv();
    set_xfer(32'h0000_2000, 2'd2, 3'd3, 1, 1);
    step();
    chk("ovr_nonseq_burst", burst_ip, 3'd3);
    adv();
    set_xfer(32'h0000_2004, 2'd3, 3'd3, 1, 1);
    step();
    chk("ovr_restored", burst_ip, 3'd3);
    adv();

    // Two-cycle error response
    set_idle();
    set_xfer(32'h3000_0000, 2'd2, 3'd0, 1, 1);
    step(); adv();
    set_idle(); resp_ip = 1; readyout_ip = 0; HREADYS = 0;
    step();
    chk("err1_resp", HRESPS, 1'b1);
    chk("err1_ready", HREADYOUTS, 1'b0);
    adv();
    resp_ip = 1; readyout_ip = 1;
    step();
    chk("err2_resp", HRESPS, 1'b1);
    chk("err2_ready", HREADYOUTS, 1'b1);
    adv();

    // Reset while holding
    set_idle();
    set_xfer(32'h5000_0000, 2'd2, 3'd0, 0, 1);
    step(); adv();
    HSELS = 0; HREADYS = 0; HTRANSS = 2'd0; active_ip = 0;
    step();
    chk("prerst_ready", HREADYOUTS, 1'b0);
    HRESETn = 0;
    #1;
    chk("rst_mid_ready", HREADYOUTS, 1'b1);
    chk("rst_mid_resp", HRESPS, 1'b0);
    chk("rst_mid_held", held_tran_ip, 1'b0);
    model_reset();
    model_check();
    @(negedge HCLK);
    HRESETn = 1;
    set_idle();
    step(); adv();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      HSELS       = ($urandom_range(0, 3) != 0);
      HADDRS      = $urandom;
      HTRANSS     = 2'($urandom_range(0, 3));
      HWRITES     = 1'($urandom);
      HSIZES      = 3'($urandom_range(0, 2));
      HBURSTS     = 3'($urandom_range(0, 7));
      HPROTS      = 4'($urandom);
      HMASTERS    = 4'($urandom);
      HMASTLOCKS  = ($urandom_range(0, 7) == 0);
      HREADYS     = m_pending ? 1'b0 : ($urandom_range(0, 3) != 0);
      active_ip   = 1'($urandom);
      readyout_ip = ($urandom_range(0, 3) != 0);
      resp_ip     = ($urandom_range(0, 5) == 0);
      step();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
